instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_if.sv | 22 ++
 rtl/instruction_fetch.sv | 128 ++++++++++++
 2 files changed

// File: rtl/instruction_fetch_if.sv
// Instruction-memory bus between the fetch unit (master) and the memory (slave).
// The fetch unit holds request and address stable until the memory answers with ready.
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: requests one word at the current pc, presents it to
// decode until it is consumed, then computes the next pc (sequential, branch or jump).
// A halt reported by the decoder freezes fetch until reset.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  instruction_fetch_if.master        imem,
  output logic [31:0]                inst,
  output logic [5:0]                 opcode,
  output logic [5:0]                 func,
  output logic                       inst_valid,
  output logic [31:0]                pc,
  output logic [31:0]                pc_plus4,
  input  logic                       advance,
  input  logic                       branch,
  input  logic                       branch_taken,
  input  logic                       jump,
  input  logic                       halted,
  output logic                       halt_out
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic        halt_q, halt_d;

  logic [31:0] pc_plus4_s;
  logic [31:0] branch_off_s;
  logic [31:0] next_pc_s;

  assign pc_plus4_s   = pc_q + 32'd4;
  assign branch_off_s = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};

  // Redirect target for the presented instruction: jump beats taken branch beats fall-through.
  always_comb begin
    next_pc_s = pc_plus4_s;
    if (jump) begin
      next_pc_s = {pc_plus4_s[31:28], inst_q[25:0], 2'b00};
    end else if (branch && branch_taken) begin
      next_pc_s = pc_plus4_s + branch_off_s;
    end else begin
      next_pc_s = pc_plus4_s;
    end
    next_pc_s[1:0] = 2'b00;
  end

  // Next-state logic: load on ready in FETCH, wait for consume or halt in HOLD, park in HALT.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    halt_d       = halt_q;
    case (state_q)
      S_FETCH: begin
        if (imem.imem_ready) begin
          inst_d       = imem.imem_rdata;
          inst_valid_d = 1'b1;
          state_d      = S_HOLD;
        end else begin
          state_d      = S_FETCH;
        end
      end
      S_HOLD: begin
        if (halted) begin
          inst_valid_d = 1'b0;
          halt_d       = 1'b1;
          state_d      = S_HALT;
        end else if (advance) begin
          pc_d         = next_pc_s;
          inst_valid_d = 1'b0;
          state_d      = S_FETCH;
        end else begin
          state_d      = S_HOLD;
        end
      end
      S_HALT: begin
        inst_valid_d = 1'b0;
        halt_d       = 1'b1;
        state_d      = S_HALT;
      end
      default: begin
        inst_valid_d = 1'b0;
        halt_d       = 1'b0;
        state_d      = S_FETCH;
      end
    endcase
  end

  // State and datapath registers; reset restarts fetch at RESET_PC and drops any pending word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      inst_q       <= 32'h0000_0000;
      inst_valid_q <= 1'b0;
      halt_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      halt_q       <= halt_d;
    end
  end

  // Request is gated by rst so nothing is issued in a reset cycle, even from a stale FETCH state.
  assign imem.imem_req  = (state_q == S_FETCH) && !rst;
  assign imem.imem_addr = pc_q;

  assign inst       = inst_q;
  assign opcode     = inst_q[31:26];
  assign func       = inst_q[5:0];
  assign inst_valid = inst_valid_q;
  assign pc         = pc_q;
  assign pc_plus4   = pc_plus4_s;
  assign halt_out   = halt_q;

endmodule
